radix2_divider: RTL and testbench

- Multi-cycle restoring divider; responder side of the divider handshake driven by the MDU front-end in the EX stage.
- Accepts one RV64M DIV/DIVU/REM/REMU (or W-variant) request when idle.
- Iterates one quotient bit per cycle and presents quotient and remainder together with a one-cycle out_valid pulse.

---
 rtl/radix2_divider_pkg.sv | 15 +
 rtl/radix2_divider_if.sv | 27 ++
 rtl/radix2_div_signfix.sv | 76 +++++++
 rtl/radix2_divider.sv | 171 +++++++++++++++++
 tb/tb_radix2_divider.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/radix2_divider_pkg.sv
// Shared constants and types for the radix-2 restoring divider.
package div_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/radix2_divider_if.sv
// Request/response bundle between the MDU front-end (master) and the divider (slave).
interface radix2_divider_if #(
  parameter int XLEN = div_pkg::XLEN
);

  logic            flush;
  logic            in_valid;
  logic            divw;
  logic            div_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output flush, in_valid, divw, div_signed, dividend, divisor,
    input  out_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  flush, in_valid, divw, div_signed, dividend, divisor,
    output out_ready, out_valid, quotient, remainder
  );

endinterface

// File: rtl/radix2_div_signfix.sv
// Combinational sign handling: operand extension/abs and special-case detection on
// the way in, negation and 32-bit sign extension of the raw results on the way out.
module radix2_div_signfix #(
  parameter int XLEN = div_pkg::XLEN
) (
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] abs_dividend,
  output logic [XLEN-1:0] abs_divisor,
  output logic            neg_q,
  output logic            neg_r,
  output logic            special,
  output logic [XLEN-1:0] special_q,
  output logic [XLEN-1:0] special_r,
  input  logic            res_divw,
  input  logic            res_neg_q,
  input  logic            res_neg_r,
  input  logic [XLEN-1:0] raw_q,
  input  logic [XLEN-1:0] raw_r,
  output logic [XLEN-1:0] fix_q,
  output logic [XLEN-1:0] fix_r
);
  import div_pkg::*;

  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] a_sx32;
  logic [XLEN-1:0] neg_q_val;
  logic [XLEN-1:0] neg_r_val;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            overflow;

  always_comb begin
    if (divw) begin
      a_ext = {{(XLEN-32){div_signed & dividend[31]}}, dividend[31:0]};
      b_ext = {{(XLEN-32){div_signed & divisor[31]}}, divisor[31:0]};
    end else begin
      a_ext = dividend;
      b_ext = divisor;
    end
    a_neg        = div_signed & a_ext[XLEN-1];
    b_neg        = div_signed & b_ext[XLEN-1];
    abs_dividend = a_neg ? -a_ext : a_ext;
    abs_divisor  = b_neg ? -b_ext : b_ext;
    neg_q        = a_neg ^ b_neg;
    neg_r        = a_neg;

    div_zero = divw ? (divisor[31:0] == '0) : (divisor == '0);
    overflow = div_signed &
               (divw ? (dividend[31:0] == 32'h8000_0000 && divisor[31:0] == '1)
                     : (dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1));
    special  = div_zero | overflow;

    // A 32-bit dividend is reported sign-extended even for the unsigned W forms.
    a_sx32 = {{(XLEN-32){dividend[31]}}, dividend[31:0]};
    if (div_zero) begin
      special_q = DIV_ZERO_Q;
      special_r = divw ? a_sx32 : dividend;
    end else begin
      special_q = divw ? a_sx32 : dividend;
      special_r = '0;
    end
  end

  always_comb begin
    neg_q_val = res_neg_q ? -raw_q : raw_q;
    neg_r_val = res_neg_r ? -raw_r : raw_r;
    fix_q     = res_divw ? {{(XLEN-32){neg_q_val[31]}}, neg_q_val[31:0]} : neg_q_val;
    fix_r     = res_divw ? {{(XLEN-32){neg_r_val[31]}}, neg_r_val[31:0]} : neg_r_val;
  end

endmodule

// File: rtl/radix2_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, for RV64M DIV/REM (and W forms).
// Define RADIX2_DIVIDER_FAST_EN to short-circuit divide-by-zero and signed overflow at accept.
module radix2_divider #(
  parameter int XLEN = div_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset,
  radix2_divider_if.slave div_bus
);
  import div_pkg::*;

  div_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  counter_reg, counter_next;
  logic              last_reg, last_next;
  logic [XLEN-1:0]   rem_reg, rem_next;
  logic [XLEN-1:0]   dvd_reg, dvd_next;
  logic [XLEN-1:0]   dvs_reg, dvs_next;
  logic              neg_q_reg, neg_q_next;
  logic              neg_r_reg, neg_r_next;
  logic              divw_reg, divw_next;
  logic              special_reg, special_next;
  logic [XLEN-1:0]   spec_q_reg, spec_q_next;
  logic [XLEN-1:0]   spec_r_reg, spec_r_next;
  logic [XLEN-1:0]   quotient_reg, quotient_next;
  logic [XLEN-1:0]   remainder_reg, remainder_next;

  logic [XLEN-1:0]   abs_dividend, abs_divisor;
  logic              in_neg_q, in_neg_r, in_special;
  logic [XLEN-1:0]   in_spec_q, in_spec_r;
  logic [XLEN-1:0]   fix_q, fix_r;
  logic [XLEN:0]     rem_shift, trial;
  logic              q_bit, accept;

  radix2_div_signfix #(.XLEN(XLEN)) u_signfix (
    .divw         (div_bus.divw),
    .div_signed   (div_bus.div_signed),
    .dividend     (div_bus.dividend),
    .divisor      (div_bus.divisor),
    .abs_dividend (abs_dividend),
    .abs_divisor  (abs_divisor),
    .neg_q        (in_neg_q),
    .neg_r        (in_neg_r),
    .special      (in_special),
    .special_q    (in_spec_q),
    .special_r    (in_spec_r),
    .res_divw     (divw_reg),
    .res_neg_q    (neg_q_reg),
    .res_neg_r    (neg_r_reg),
    .raw_q        (dvd_reg),
    .raw_r        (rem_reg),
    .fix_q        (fix_q),
    .fix_r        (fix_r)
  );

  assign accept    = div_bus.in_valid & (state_reg == IDLE) & ~div_bus.flush;
  assign rem_shift = {rem_reg, dvd_reg[XLEN-1]};
  assign trial     = rem_shift - {1'b0, dvs_reg};
  assign q_bit     = ~trial[XLEN];

  always_comb begin
    state_next     = state_reg;
    counter_next   = counter_reg;
    last_next      = last_reg;
    rem_next       = rem_reg;
    dvd_next       = dvd_reg;
    dvs_next       = dvs_reg;
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;
    divw_next      = divw_reg;
    special_next   = special_reg;
    spec_q_next    = spec_q_reg;
    spec_r_next    = spec_r_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          // W operands are parked in the top half so the MSB-first shift sees bit 31 first.
          dvd_next     = div_bus.divw ? {abs_dividend[31:0], {(XLEN-32){1'b0}}} : abs_dividend;
          rem_next     = '0;
          dvs_next     = abs_divisor;
          neg_q_next   = in_neg_q;
          neg_r_next   = in_neg_r;
          divw_next    = div_bus.divw;
          special_next = in_special;
          spec_q_next  = in_spec_q;
          spec_r_next  = in_spec_r;
          counter_next = div_bus.divw ? CNT_W'(31) : CNT_W'(XLEN-1);
          last_next    = 1'b0;
`ifdef RADIX2_DIVIDER_FAST_EN
          if (in_special) begin
            state_next     = DONE;
            quotient_next  = in_spec_q;
            remainder_next = in_spec_r;
          end else begin
            state_next = BUSY;
          end
`else
          state_next = BUSY;
`endif
        end
      end
      BUSY: begin
        if (!last_reg) begin
          rem_next = q_bit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
          dvd_next = {dvd_reg[XLEN-2:0], q_bit};
          if (counter_reg == '0) begin
            last_next = 1'b1;
          end else begin
            counter_next = counter_reg - 1'b1;
          end
        end else begin
          // Extra cycle after the last step keeps the sign fix-up off the subtract path.
          state_next     = DONE;
          last_next      = 1'b0;
          quotient_next  = special_reg ? spec_q_reg : fix_q;
          remainder_next = special_reg ? spec_r_reg : fix_r;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (div_bus.flush) begin
      state_next     = IDLE;
      quotient_next  = quotient_reg;
      remainder_next = remainder_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      counter_reg   <= '0;
      last_reg      <= 1'b0;
      rem_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      divw_reg      <= 1'b0;
      special_reg   <= 1'b0;
      spec_q_reg    <= '0;
      spec_r_reg    <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      state_reg     <= state_next;
      counter_reg   <= counter_next;
      last_reg      <= last_next;
      rem_reg       <= rem_next;
      dvd_reg       <= dvd_next;
      dvs_reg       <= dvs_next;
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
      divw_reg      <= divw_next;
      special_reg   <= special_next;
      spec_q_reg    <= spec_q_next;
      spec_r_reg    <= spec_r_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
    end
  end

  assign div_bus.out_ready = (state_reg == IDLE);
  assign div_bus.out_valid = (state_reg == DONE);
  assign div_bus.quotient  = quotient_reg;
  assign div_bus.remainder = remainder_reg;

endmodule

// File: tb/tb_radix2_divider.sv
// Scoreboard bench for radix2_divider: issued requests push expected results from an
// arithmetic reference; a negedge monitor pops and compares on every out_valid.
`timescale 1ns/1ps
module tb_radix2_divider;

  localparam int W = 64;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          due;
    int          id;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  radix2_divider_if #(.XLEN(W)) dif ();
  radix2_divider #(.XLEN(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .div_bus (dif)
  );

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_issued = 0;
  logic        prev_valid = 1'b0;
  logic [63:0] last_q = '0;
  logic [63:0] last_r = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V M-extension semantics from plain integer arithmetic.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  input logic w, input logic s,
                                  output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    int          sa32, sb32;
    longint      sa, sbv;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF;
        r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32;
        r32 = 32'd0;
      end else if (s) begin
        sa32 = $signed(a32);
        sb32 = $signed(b32);
        q32  = 32'(sa32 / sb32);
        r32  = 32'(sa32 % sb32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin
        q = '1;
        r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a;
        r = '0;
      end else if (s) begin
        sa  = $signed(a);
        sbv = $signed(b);
        q   = 64'(sa / sbv);
        r   = 64'(sa % sbv);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  function automatic bit is_special(input logic [63:0] a, input logic [63:0] b,
                                    input logic w, input logic s);
    if (w) return (b[31:0] == 32'd0) ||
                  (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w, input logic s);
    exp_t e;
    int   lat;
    bit   ok;
    ok = 1'b0;
    @(negedge clock);
    dif.in_valid   = 1'b1;
    dif.dividend   = a;
    dif.divisor    = b;
    dif.divw       = w;
    dif.div_signed = s;
    for (int i = 0; i < 300; i++) begin
      if (dif.out_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got out_ready=0 expected 1 within 300 cycles");
      dif.in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    ref_div(a, b, w, s, e.q, e.r);
    lat = (w ? 32 : 64) + 1;
`ifdef RADIX2_DIVIDER_FAST_EN
    if (is_special(a, b, w, s)) lat = 0;
`endif
    e.due = cyc + lat;
    e.id  = n_issued++;
    sb.push_back(e);
    dif.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    case ($urandom_range(0, 4))
      0:       v = {$urandom, $urandom};
      1:       v = 64'($urandom_range(0, 200));
      2:       v = -64'($urandom_range(1, 200));
      3:       v = {32'h0, $urandom};
      default: v = {32'hFFFF_FFFF, $urandom};
    endcase
    return v;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (sb.size() != 0) chk("ready_low_busy", 64'(dif.out_ready), 64'd0);
      if (dif.out_valid) begin
        chk("valid_single_pulse", 64'(prev_valid), 64'd0);
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got out_valid=1 expected 0 (q=%h r=%h)",
                   dif.quotient, dif.remainder);
        end else begin
          e = sb.pop_front();
          chk("quotient", dif.quotient, e.q);
          chk("remainder", dif.remainder, e.r);
          chk("latency_cycle", 64'(cyc), 64'(e.due));
          last_q = e.q;
          last_r = e.r;
          $display("op %0d: q=%h r=%h at cycle %0d", e.id, dif.quotient, dif.remainder, cyc);
        end
      end
      prev_valid = dif.out_valid;
    end
  end

  initial begin
    logic [63:0] a, b;
    logic        w, s;
    bit          ok;

    dif.flush      = 1'b0;
    dif.in_valid   = 1'b0;
    dif.divw       = 1'b0;
    dif.div_signed = 1'b0;
    dif.dividend   = '0;
    dif.divisor    = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_out_valid", 64'(dif.out_valid), 64'd0);
    chk("reset_out_ready", 64'(dif.out_ready), 64'd1);
    chk("reset_quotient", dif.quotient, 64'd0);
    chk("reset_remainder", dif.remainder, 64'd0);

    issue(64'd100, 64'd7, 1'b0, 1'b0);
    issue(-64'd7, 64'd2, 1'b0, 1'b1);
    issue(64'h1234, 64'd0, 1'b0, 1'b1);
    issue(64'h1234, 64'd0, 1'b0, 1'b0);
    issue(64'h8000_0000_0000_0000, '1, 1'b0, 1'b1);
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1);
    issue(64'h0000_0000_FFFF_FFFE, 64'd1, 1'b1, 1'b0);
    drain();

    // Flush twenty cycles into an operation: no result, idle next cycle, outputs kept.
    issue(64'd12345, 64'd11, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    dif.flush = 1'b1;
    @(posedge clock);
    #1;
    sb.delete();
    dif.flush = 1'b0;
    @(negedge clock);
    chk("flush_ready", 64'(dif.out_ready), 64'd1);
    chk("flush_keeps_quotient", dif.quotient, last_q);
    chk("flush_keeps_remainder", dif.remainder, last_r);
    issue(64'd9, 64'd3, 1'b0, 1'b0);
    drain();

    // Flush together with a request: it must not be taken.
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dif.out_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("idle_before_flush_req", 64'(ok), 64'd1);
    dif.in_valid = 1'b1;
    dif.flush    = 1'b1;
    dif.dividend = 64'd50;
    dif.divisor  = 64'd5;
    dif.divw     = 1'b0;
    @(posedge clock);
    #1;
    dif.in_valid = 1'b0;
    dif.flush    = 1'b0;
    @(negedge clock);
    chk("flush_req_not_accepted", 64'(dif.out_ready), 64'd1);
    repeat (70) @(negedge clock);

    // Reset in the middle of an operation clears the results.
    issue({$urandom, $urandom}, 64'd3, 1'b0, 1'b0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    sb.delete();
    reset = 1'b0;
    @(negedge clock);
    chk("midop_reset_ready", 64'(dif.out_ready), 64'd1);
    chk("midop_reset_quotient", dif.quotient, 64'd0);
    chk("midop_reset_remainder", dif.remainder, 64'd0);

    for (int n = 0; n < 40; n++) begin
      a = rnd_op();
      b = rnd_op();
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin
          a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
          b = '1;
          s = 1'b1;
        end
        default: ;
      endcase
      issue(a, b, w, s);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: got no completion expected finish before 400000 ns");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
